// File: rtl/load_store_unit_pkg.sv
// Shared ISA definitions for the load/store path: data width, funct3 width encodings,
// FSM state type and small decode helpers used by the LSU and its alignment datapath.
package load_store_unit_pkg;

  localparam int XLEN = 32;

  // Load and store funct3 share the width encodings; bit 2 selects zero-extension.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  // Unlisted encodings fall through to word accesses.
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  function automatic logic f3_signed(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3_size(f3))
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and load extract/extension.
// Halfwords use only addr[1] and words ignore the low address bits, so misaligned offsets round down.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] rdata_ext
);

  lsu_size_e       size;
  logic [1:0]      off;
  logic [XLEN-1:0] shifted;
  logic            sgn;

  always_comb begin
    size      = f3_size(funct3);
    off       = 2'b00;
    be        = 4'b1111;
    wdata_rep = wdata;
    case (size)
      SZ_BYTE: begin
        off       = addr_lo;
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        off       = {addr_lo[1], 1'b0};
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = rdata >> {off, 3'b000};
  assign sgn     = f3_signed(funct3);

  always_comb begin
    rdata_ext = shifted;
    case (size)
      SZ_BYTE: rdata_ext = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_ext = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE->REQ->(WAIT)->RESP; store 2, load 3 cycles minimum.
// Stalls decode via busy/req_ready; LSU_MISALIGN_TRAP_EN turns misaligned accesses into exceptions.
module load_store_unit #(
  parameter int XLEN = load_store_unit_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] load_data,
  output logic            misalign_exc,
  output logic            busy,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);
  import load_store_unit_pkg::*;

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            is_load_q, is_load_d, misalign_q, misalign_d;
  logic            accept, req_misaligned;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_rep, rdata_ext;

  assign accept = (state_q == ST_IDLE) && req_valid && (is_load || is_store);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misaligned = is_misaligned(funct3, addr[1:0]);
`else
  assign req_misaligned = 1'b0;
`endif

  lsu_align u_align (
    .funct3    (funct3_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (dmem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    is_load_d   = is_load_q;
    misalign_d  = misalign_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        addr_d     = addr;
        wdata_d    = wdata;
        funct3_d   = funct3;
        is_load_d  = is_load;
        misalign_d = req_misaligned;
        if (req_misaligned) begin
          state_d = ST_RESP;
          if (is_load) load_data_d = '0;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ:  if (dmem_gnt) state_d = is_load_q ? ST_WAIT : ST_RESP;
      // rvalid only matters here; grant-cycle or post-reset pulses never reach this branch.
      ST_WAIT: if (dmem_rvalid) begin
        load_data_d = rdata_ext;
        state_d     = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      funct3_q    <= 3'b000;
      is_load_q   <= 1'b0;
      misalign_q  <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      is_load_q   <= is_load_d;
      misalign_q  <= misalign_d;
      load_data_q <= load_data_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = ~req_ready;
  assign resp_valid   = (state_q == ST_RESP);
  assign misalign_exc = resp_valid && misalign_q;
  // Stores report zero; otherwise the last load result is held.
  assign load_data    = (resp_valid && !is_load_q) ? '0 : load_data_q;
  assign dmem_req     = (state_q == ST_REQ);
  assign dmem_we      = dmem_req && !is_load_q;
  assign dmem_addr    = dmem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign dmem_be      = dmem_req ? be : 4'b0000;
  assign dmem_wdata   = dmem_we ? wdata_rep : '0;

endmodule
